// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one single-beat 128-bit AXI read port among NUM_REQ requesters.
// Optional R-wait timeout is enabled by defining AXI_RD_TIMEOUT_EN.
module axi_read_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*3-1:0]          req_size,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_data,
  output logic [1:0]                    rsp_resp,
  output logic                          arvalid,
  input  logic                          arready,
  output logic [ADDR_WIDTH-1:0]         araddr,
  output logic [ID_WIDTH-1:0]           arid,
  output logic [2:0]                    arsize,
  output logic [7:0]                    arlen,
  output logic [1:0]                    arburst,
  input  logic                          rvalid,
  output logic                          rready,
  input  logic [AXI_DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                    rresp,
  input  logic [ID_WIDTH-1:0]           rid,
  input  logic                          rlast
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      ptr_after_grant;
  logic                  grant_found;
  logic                  grant_ok;
  logic                  beat_match;
  logic                  timeout_hit;
  logic [ADDR_WIDTH-1:0] addr_slice [NUM_REQ];
  logic [2:0]            size_slice [NUM_REQ];
  logic                  unused_ok;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_slice[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      size_slice[i] = req_size[i*3 +: 3];
    end
  end

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    logic [PTR_W:0] cand_sum;
    logic [PTR_W:0] next_sum;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(NUM_REQ))
        cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand_sum[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sum[PTR_W-1:0];
      end
    end
    next_sum = {1'b0, grant_idx} + (PTR_W+1)'(1);
    if (next_sum >= (PTR_W+1)'(NUM_REQ))
      next_sum = '0;
    ptr_after_grant = next_sum[PTR_W-1:0];
  end

  // The rsp_valid cycle is spent in IDLE without granting.
  assign grant_ok   = rst_n && (state == IDLE) && (rsp_valid == '0) && grant_found;
  assign req_ready  = grant_ok ? (NUM_REQ'(1) << grant_idx) : '0;
  assign beat_match = (state == R) && rvalid && (rid == arid);

  assign arvalid = (state == AR);
  assign rready  = (state == R);
  assign arlen   = 8'd0;
  assign arburst = 2'b01;

`ifdef AXI_RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (state != R)
      to_cnt <= '0;
    else if (!beat_match)
      to_cnt <= to_cnt + TO_W'(1);
  end

  assign timeout_hit = (state == R) && !beat_match && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_ok) state_next = AR;
      AR:      if (arready) state_next = R;
      R:       if (beat_match || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      araddr    <= '0;
      arid      <= '0;
      arsize    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_resp  <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= '0;
      if (grant_ok) begin
        araddr <= addr_slice[grant_idx];
        arsize <= size_slice[grant_idx];
        arid   <= ID_WIDTH'(grant_idx);
        rr_ptr <= ptr_after_grant;
      end
      if (beat_match) begin
        rsp_data  <= rdata;
        rsp_resp  <= rresp;
        rsp_valid <= NUM_REQ'(1) << arid;
      end else if (timeout_hit) begin
        rsp_data  <= '0;
        rsp_resp  <= 2'b10;
        rsp_valid <= NUM_REQ'(1) << arid;
      end
    end
  end

  // rlast carries no information with single-beat reads.
  assign unused_ok = rlast | (TIMEOUT_CYCLES == 0);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed scenarios plus random traffic,
// compared against a transaction-level reference model. Timeout scenario needs AXI_RD_TIMEOUT_EN.
module tb_axi_read_arbiter;

  localparam int NUM_REQ        = 3;
  localparam int ADDR_WIDTH     = 32;
  localparam int AXI_DATA_WIDTH = 128;
  localparam int ID_WIDTH       = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*3-1:0]          req_size;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [AXI_DATA_WIDTH-1:0]     rsp_data;
  logic [1:0]                    rsp_resp;
  logic                          arvalid;
  logic                          arready;
  logic [ADDR_WIDTH-1:0]         araddr;
  logic [ID_WIDTH-1:0]           arid;
  logic [2:0]                    arsize;
  logic [7:0]                    arlen;
  logic [1:0]                    arburst;
  logic                          rvalid;
  logic                          rready;
  logic [AXI_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                    rresp;
  logic [ID_WIDTH-1:0]           rid;
  logic                          rlast;

  always #5 clk = ~clk;

  axi_read_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .ID_WIDTH      (ID_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_size (req_size),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_resp (rsp_resp),
    .arvalid  (arvalid),
    .arready  (arready),
    .araddr   (araddr),
    .arid     (arid),
    .arsize   (arsize),
    .arlen    (arlen),
    .arburst  (arburst),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rid      (rid),
    .rlast    (rlast)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Reference model: one outstanding transaction tracked by its protocol progress.
  int               m_ptr;
  bit               m_busy, m_ar, m_r, m_due;
  int               m_owner;
  logic [31:0]      m_addr;
  logic [2:0]       m_size;
  logic [127:0]     m_data;
  logic [1:0]       m_resp;
  int               m_rwait;

  int               grant_log[$];
  int               obs_grant_cycle, obs_rsp_cycle;
  int               arvalid_cycles, rsp_count;
  logic [2:0]       obs_rsp_bits;
  logic [1:0]       obs_rsp_resp;
  logic [127:0]     obs_rsp_data;

  function automatic int rr_pick(input logic [2:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_busy  = 0;
    m_ar    = 0;
    m_r     = 0;
    m_due   = 0;
    m_owner = 0;
    m_addr  = '0;
    m_size  = '0;
    m_data  = '0;
    m_resp  = '0;
    m_rwait = 0;
  endtask

  task automatic clear_obs();
    grant_log.delete();
    arvalid_cycles = 0;
    rsp_count      = 0;
    obs_grant_cycle = -100;
    obs_rsp_cycle   = -1;
    obs_rsp_bits    = '0;
    obs_rsp_resp    = '0;
    obs_rsp_data    = '0;
  endtask

  task automatic apply_stimulus(input logic [2:0] v, input logic ar, input logic rv,
                                input logic [3:0] id, input logic [1:0] resp,
                                input logic [127:0] data);
    req_valid = v;
    arready   = ar;
    rvalid    = rv;
    rid       = id;
    rresp     = resp;
    rdata     = data;
    rlast     = rv;
  endtask

  // Compare every output against the model, then advance the model across the coming edge.
  task automatic sample_and_update();
    int         pick;
    logic [2:0] exp_ready;
    logic [2:0] exp_rsp;
    pick      = m_busy ? -1 : rr_pick(req_valid, m_ptr);
    exp_ready = (pick >= 0) ? 3'(1 << pick) : 3'b000;
    exp_rsp   = m_due ? 3'(1 << m_owner) : 3'b000;
    check_output("req_ready", req_ready, exp_ready);
    check_output("arvalid", arvalid, m_ar);
    check_output("rready", rready, m_r);
    check_output("rsp_valid", rsp_valid, exp_rsp);
    check_output("rsp_data", rsp_data, m_data);
    check_output("rsp_resp", rsp_resp, m_resp);
    if (m_ar) begin
      check_output("araddr", araddr, m_addr);
      check_output("arid", arid, m_owner);
      check_output("arsize", arsize, m_size);
    end
    if (req_ready != 0) begin
      grant_log.push_back($clog2(req_ready));
      obs_grant_cycle = cycle;
    end
    if (arvalid) arvalid_cycles++;
    if (rsp_valid != 0) begin
      rsp_count++;
      obs_rsp_cycle = cycle;
      obs_rsp_bits  = rsp_valid;
      obs_rsp_resp  = rsp_resp;
      obs_rsp_data  = rsp_data;
    end
    if (pick >= 0) begin
      m_busy  = 1;
      m_ar    = 1;
      m_owner = pick;
      m_addr  = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
      m_size  = req_size[pick*3 +: 3];
      m_ptr   = (pick + 1) % NUM_REQ;
    end else if (m_ar) begin
      if (arready) begin
        m_ar    = 0;
        m_r     = 1;
        m_rwait = 0;
      end
    end else if (m_r) begin
      if (rvalid && int'(rid) == m_owner) begin
        m_r    = 0;
        m_due  = 1;
        m_data = rdata;
        m_resp = rresp;
      end else begin
        m_rwait++;
`ifdef AXI_RD_TIMEOUT_EN
        if (m_rwait == TIMEOUT_CYCLES) begin
          m_r    = 0;
          m_due  = 1;
          m_data = '0;
          m_resp = 2'b10;
        end
`endif
      end
    end else if (m_due) begin
      m_due  = 0;
      m_busy = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample_and_update();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic randomize_addrs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = $urandom;
      req_size[i*3 +: 3] = 3'($urandom_range(0, 4));
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset(input bit check_in_r);
    req_valid = 3'b111;
    #2;
    if (check_in_r) check_output("in_r_before_reset", rready, 1'b1);
    rst_n = 1'b0;
    #1;
    check_output("rst_arvalid", arvalid, 1'b0);
    check_output("rst_rready", rready, 1'b0);
    check_output("rst_rsp_valid", rsp_valid, 3'b000);
    check_output("rst_req_ready", req_ready, 3'b000);
    check_output("rst_araddr", araddr, 32'h0);
    check_output("rst_arid", arid, 4'h0);
    check_output("rst_arsize", arsize, 3'h0);
    check_output("rst_rsp_data", rsp_data, 128'h0);
    check_output("rst_rsp_resp", rsp_resp, 2'h0);
    model_reset();
    apply_stimulus(3'b000, 1'b0, 1'b0, 4'h0, 2'b00, '0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  initial begin
    int got;
    int exp_order[4];
    exp_order = '{0, 1, 2, 0};

    rst_n    = 1'b0;
    req_addr = '0;
    req_size = '0;
    apply_stimulus(3'b000, 1'b0, 1'b0, 4'h0, 2'b00, '0);
    model_reset();
    clear_obs();
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // Single request with an always-ready slave.
    clear_obs();
    req_addr[31:0] = 32'h1C00_0000;
    req_size[2:0]  = 3'd4;
    apply_stimulus(3'b001, 1'b1, 1'b1, 4'h0, 2'b00, 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(3'b000, 1'b1, 1'b1, 4'h0, 2'b00, 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D);
      tick();
    end
    got = (grant_log.size() > 0) ? grant_log[0] : -1;
    check_output("single_grant_idx", got, 0);
    check_output("single_latency", obs_rsp_cycle - obs_grant_cycle, 3);
    check_output("single_rsp_count", rsp_count, 1);
    check_output("single_rsp_data", obs_rsp_data, 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D);
    check_output("arlen", arlen, 8'h00);
    check_output("arburst", arburst, 2'b01);

    // All requesters continuously valid from reset.
    do_reset(1'b0);
    clear_obs();
    for (int i = 0; i < 24; i++) begin
      randomize_addrs();
      apply_stimulus(3'b111, 1'b1, 1'b1, 4'(m_owner), 2'b00, {$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < grant_log.size()) ? grant_log[i] : -1;
      check_output($sformatf("contention_grant%0d", i), got, exp_order[i]);
    end

    // AR backpressure: arready low for 5 cycles while requester addresses keep changing.
    clear_obs();
    randomize_addrs();
    apply_stimulus(3'b100, 1'b0, 1'b0, 4'h0, 2'b00, '0);
    tick();
    for (int i = 0; i < 5; i++) begin
      randomize_addrs();
      apply_stimulus(3'b000, 1'b0, 1'b0, 4'h0, 2'b00, '0);
      tick();
    end
    check_output("bp_no_early_rsp", rsp_count, 0);
    apply_stimulus(3'b000, 1'b1, 1'b0, 4'h0, 2'b00, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(3'b000, 1'b0, 1'b1, 4'h2, 2'b00, 128'h1234);
      tick();
    end
    check_output("bp_arvalid_cycles", arvalid_cycles, 6);
    check_output("bp_rsp_count", rsp_count, 1);

    // Stray beat with a foreign ID, then a matching SLVERR beat.
    clear_obs();
    randomize_addrs();
    apply_stimulus(3'b010, 1'b1, 1'b0, 4'h0, 2'b00, '0);
    tick();
    apply_stimulus(3'b000, 1'b1, 1'b0, 4'h0, 2'b00, '0);
    tick();
    apply_stimulus(3'b000, 1'b0, 1'b1, 4'h3, 2'b00, 128'hAAAA_5555);
    tick();
    apply_stimulus(3'b000, 1'b0, 1'b1, 4'h1, 2'b10, 128'hC0FFEE);
    tick();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(3'b000, 1'b0, 1'b0, 4'h0, 2'b00, '0);
      tick();
    end
    check_output("err_rsp_count", rsp_count, 1);
    check_output("err_rsp_bits", obs_rsp_bits, 3'b010);
    check_output("err_rsp_resp", obs_rsp_resp, 2'b10);
    check_output("err_rsp_data", obs_rsp_data, 128'hC0FFEE);

    // Asynchronous reset while waiting in R, then a fresh request restarts at pointer 0.
    randomize_addrs();
    apply_stimulus(3'b001, 1'b1, 1'b0, 4'h0, 2'b00, '0);
    tick();
    apply_stimulus(3'b000, 1'b1, 1'b0, 4'h0, 2'b00, '0);
    tick();
    do_reset(1'b1);
    clear_obs();
    randomize_addrs();
    apply_stimulus(3'b010, 1'b1, 1'b0, 4'h0, 2'b00, '0);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(3'b000, 1'b1, 1'b1, 4'(m_owner), 2'b00, 128'h77);
      tick();
    end
    got = (grant_log.size() > 0) ? grant_log[0] : -1;
    check_output("post_reset_grant", got, 1);
    check_output("post_reset_rsp_bits", obs_rsp_bits, 3'b010);

`ifdef AXI_RD_TIMEOUT_EN
    // Slave never answers; the arbiter must give up with SLVERR.
    clear_obs();
    randomize_addrs();
    apply_stimulus(3'b001, 1'b1, 1'b0, 4'h0, 2'b00, '0);
    tick();
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(3'b000, 1'b1, 1'b0, 4'h0, 2'b00, '0);
      tick();
    end
    check_output("to_latency", obs_rsp_cycle - obs_grant_cycle, 2 + TIMEOUT_CYCLES);
    check_output("to_rsp_resp", obs_rsp_resp, 2'b10);
    check_output("to_rsp_data", obs_rsp_data, 128'h0);
`endif

    // Random traffic with random AR stalls, R gaps and stray IDs.
    for (int i = 0; i < 400; i++) begin
      logic       rv;
      logic [3:0] id;
      randomize_addrs();
      rv = m_r ? 1'($urandom % 2) : 1'b0;
      id = ($urandom % 4 != 0) ? 4'(m_owner) : 4'($urandom % 16);
      apply_stimulus(3'($urandom % 8), ($urandom_range(0, 3) != 0), rv, id,
                     ($urandom % 2 != 0) ? 2'b10 : 2'b00,
                     {$urandom, $urandom, $urandom, $urandom});
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
